date_count: RTL

- Calendar-date stage directly downstream of the hour counter.
- Consumes the hour counter's day-rollover pulse (its O_TRIG_F) and keeps day, month and year (2000–2099) as BCD digit pairs.
- Digits feed the display stage.
- Supports UP/DOWN field adjustment with the same debounced pulses and active-low select style as the time counters.
- Month lengths and leap years are handled exactly.

---
 rtl/date_pkg.sv | 59 +++++
 rtl/date_month_len.sv | 27 ++
 rtl/date_count.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/date_pkg.sv
// ============================================================================
// Module   : date_pkg
// Brief    : BCD calendar constants and digit helpers shared by the date stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package date_pkg;

    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_MAR = 8'h03;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_MAY = 8'h05;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_JUL = 8'h07;
    localparam logic [7:0] MON_AUG = 8'h08;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_OCT = 8'h10;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    localparam logic [7:0] DAY_01 = 8'h01;
    localparam logic [7:0] DAY_28 = 8'h28;
    localparam logic [7:0] DAY_29 = 8'h29;
    localparam logic [7:0] DAY_30 = 8'h30;
    localparam logic [7:0] DAY_31 = 8'h31;

    localparam logic [7:0] YEAR_00 = 8'h00;
    localparam logic [7:0] YEAR_99 = 8'h99;

    // Divisible by four: even tens pair with ones 0/4/8, odd tens with 2/6.
    function automatic logic is_leap_bcd(input logic [7:0] yr);
        logic [3:0] ones;
        ones = yr[3:0];
        if (yr[4] == 1'b0) begin
            return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        end
        return (ones == 4'd2) || (ones == 4'd6);
    endfunction

    // Callers never pass 99, so the tens digit cannot overflow.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/date_month_len.sv
// ============================================================================
// Module   : date_month_len
// Brief    : Last day of a BCD month, taking the leap flag into account.
// Revision : 1.0
// ============================================================================
`default_nettype none

module date_month_len
    import date_pkg::*;
(
    input  logic [7:0] mon,
    input  logic       leap,
    output logic [7:0] last_day
);

    always_comb begin
        last_day = DAY_31;
        case (mon)
            MON_FEB:                            last_day = leap ? DAY_29 : DAY_28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: last_day = DAY_30;
            default:                            last_day = DAY_31;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/date_count.sv
// ============================================================================
// Module   : date_count
// Brief    : BCD day/month/year counter (2000-2099) with field adjustment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module date_count
    import date_pkg::*;
#(
    parameter logic [7:0] PAR_RST_DAY  = 8'h01,
    parameter logic [7:0] PAR_RST_MON  = 8'h01,
    parameter logic [7:0] PAR_RST_YEAR = 8'h00
) (
    input  logic       I_SYS_CLK,
    input  logic       I_EXT_RST,
    input  logic       I_TRIG_F,
    input  logic       I_ADJ_UP,
    input  logic       I_ADJ_DOWN,
    input  logic [2:0] I_ADJ_SEL,
    output logic       O_TRIG_F,
    output logic       O_LEAP,
    output logic [3:0] O_DAYL,
    output logic [3:0] O_DAYH,
    output logic [3:0] O_MONL,
    output logic [3:0] O_MONH,
    output logic [3:0] O_YRL,
    output logic [3:0] O_YRH
);

    logic [7:0] r_day;
    logic [7:0] r_mon;
    logic [7:0] r_yr;
    logic       r_trig;

    logic [7:0] w_day_n;
    logic [7:0] w_mon_n;
    logic [7:0] w_yr_n;
    logic       w_trig_n;

    logic       w_leap;
    logic [7:0] w_last;
    logic [7:0] w_last_adj;
    logic [7:0] w_mon_step;
    logic [7:0] w_yr_step;
    logic [7:0] w_adj_mon;
    logic       w_adj_leap;
    logic       w_adj_en;
    logic       w_sel_day;
    logic       w_sel_mon;
    logic       w_sel_yr;

    assign w_leap = is_leap_bcd(r_yr);

    // Select priority day > month > year resolves multiple low bits.
    assign w_sel_day = ~I_ADJ_SEL[0];
    assign w_sel_mon =  I_ADJ_SEL[0] & ~I_ADJ_SEL[1];
    assign w_sel_yr  =  I_ADJ_SEL[0] &  I_ADJ_SEL[1] & ~I_ADJ_SEL[2];
    assign w_adj_en  = ~I_TRIG_F & (I_ADJ_UP ^ I_ADJ_DOWN);

    assign w_mon_step = I_ADJ_UP ? ((r_mon == MON_DEC) ? MON_JAN : bcd_inc(r_mon))
                                 : ((r_mon == MON_JAN) ? MON_DEC : bcd_dec(r_mon));
    assign w_yr_step  = I_ADJ_UP ? ((r_yr == YEAR_99) ? YEAR_00 : bcd_inc(r_yr))
                                 : ((r_yr == YEAR_00) ? YEAR_99 : bcd_dec(r_yr));

    // Second lookup sees the month/year as they will be after the adjust.
    assign w_adj_mon  = w_sel_mon ? w_mon_step : r_mon;
    assign w_adj_leap = w_sel_yr ? is_leap_bcd(w_yr_step) : w_leap;

    date_month_len u_len_cur (
        .mon      (r_mon),
        .leap     (w_leap),
        .last_day (w_last)
    );

    date_month_len u_len_adj (
        .mon      (w_adj_mon),
        .leap     (w_adj_leap),
        .last_day (w_last_adj)
    );

    always_comb begin
        w_day_n  = r_day;
        w_mon_n  = r_mon;
        w_yr_n   = r_yr;
        w_trig_n = 1'b0;
        if (I_TRIG_F) begin
            if (r_day == w_last) begin
                w_day_n = DAY_01;
                if (r_mon == MON_DEC) begin
                    w_mon_n = MON_JAN;
                    if (r_yr == YEAR_99) begin
                        w_yr_n   = YEAR_00;
                        w_trig_n = 1'b1;
                    end else begin
                        w_yr_n = bcd_inc(r_yr);
                    end
                end else begin
                    w_mon_n = bcd_inc(r_mon);
                end
            end else begin
                w_day_n = bcd_inc(r_day);
            end
        end else if (w_adj_en) begin
            if (w_sel_day) begin
                if (I_ADJ_UP) begin
                    w_day_n = (r_day == w_last) ? DAY_01 : bcd_inc(r_day);
                end else begin
                    w_day_n = (r_day == DAY_01) ? w_last : bcd_dec(r_day);
                end
            end else if (w_sel_mon || w_sel_yr) begin
                if (w_sel_mon) begin
                    w_mon_n = w_mon_step;
                end else begin
                    w_yr_n = w_yr_step;
                end
                // Valid BCD compares in the same order as the numbers it encodes.
                if (r_day > w_last_adj) begin
                    w_day_n = w_last_adj;
                end
            end
        end
    end

    always_ff @(posedge I_SYS_CLK) begin
        if (I_EXT_RST) begin
            r_day  <= PAR_RST_DAY;
            r_mon  <= PAR_RST_MON;
            r_yr   <= PAR_RST_YEAR;
            r_trig <= 1'b0;
        end else begin
            r_day  <= w_day_n;
            r_mon  <= w_mon_n;
            r_yr   <= w_yr_n;
            r_trig <= w_trig_n;
        end
    end

    assign O_TRIG_F = r_trig;
    assign O_LEAP   = w_leap;
    assign O_DAYL   = r_day[3:0];
    assign O_DAYH   = r_day[7:4];
    assign O_MONL   = r_mon[3:0];
    assign O_MONH   = r_mon[7:4];
    assign O_YRL    = r_yr[3:0];
    assign O_YRH    = r_yr[7:4];

endmodule

`default_nettype wire
